// File: rtl/tm_sr_sched.sv
// tm_sr_sched: base-period telemetry/service scheduler.
// A free-running base counter produces base_tick. Per-channel dividers turn base
// ticks into channel events. Each event sets a transmit-ready flag, and a sticky
// overrun flag records events that arrive while the previous one is unacknowledged.
module tm_sr_sched #(
  parameter int CLK_FREQ = 50000000,
  parameter int BASE_DIV = CLK_FREQ / 10,
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 4,
  parameter int PRE_CYC  = 37400
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*DIV_W-1:0] div,
  input  logic [NUM_CH-1:0]       tx_ack,
  input  logic [NUM_CH-1:0]       repeat_req,
  output logic [NUM_CH-1:0]       tx_rdy,
  output logic [NUM_CH-1:0]       pre_alert,
  output logic                    base_tick,
  output logic [NUM_CH-1:0]       ovr,
  input  logic [NUM_CH-1:0]       ovr_clr
);

  localparam int             BW        = $clog2(BASE_DIV);
  localparam logic [BW-1:0]  BASE_LAST = BW'(BASE_DIV - 1);
  // First base count of the pre-alert window; equals BASE_LAST when PRE_CYC=0,
  // which leaves the window empty because the tick cycle itself is excluded.
  localparam logic [BW-1:0]  PRE_START = BW'(BASE_DIV - 1 - PRE_CYC);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [BW-1:0]     base_cnt_q, base_cnt_d;
  logic [DIV_W-1:0]  ch_cnt_q [NUM_CH];
  logic [DIV_W-1:0]  ch_cnt_d [NUM_CH];
  logic [DIV_W-1:0]  div_m1_s [NUM_CH];
  logic [NUM_CH-1:0] tx_rdy_q, tx_rdy_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic              tick_s;
  logic [NUM_CH-1:0] at_end_s, evt_s, pa_s;

  // Base period strobe, held low while reset is applied.
  always_comb begin
    tick_s = 1'b0;
    if (rst) begin
      tick_s = 1'b0;
    end else begin
      tick_s = (base_cnt_q == BASE_LAST);
    end
  end

  // Per-channel terminal-count compare, events and pre-alert window.
  always_comb begin
    at_end_s = {NUM_CH{1'b0}};
    evt_s    = {NUM_CH{1'b0}};
    pa_s     = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      div_m1_s[k] = DIV_ZERO;
      // A divider of 0 behaves as 1, so the terminal count is 0 in both cases.
      if (div[k*DIV_W +: DIV_W] == DIV_ZERO) begin
        div_m1_s[k] = DIV_ZERO;
      end else begin
        div_m1_s[k] = div[k*DIV_W +: DIV_W] - DIV_ONE;
      end
      // A greater-or-equal compare lets a divider lowered below the current count
      // fire on the next tick rather than wrap the counter.
      at_end_s[k] = (ch_cnt_q[k] >= div_m1_s[k]);
      evt_s[k]    = tick_s & en[k] & at_end_s[k];
      if (base_cnt_q >= PRE_START) begin
        pa_s[k] = en[k] & at_end_s[k] & ~tick_s & ~rst;
      end else begin
        pa_s[k] = 1'b0;
      end
    end
  end

  // Next-state logic for the base counter, channel counters and flags.
  always_comb begin
    if (tick_s) begin
      base_cnt_d = BW'(0);
    end else begin
      base_cnt_d = base_cnt_q + BW'(1);
    end
    tx_rdy_d = tx_rdy_q;
    ovr_d    = ovr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_cnt_d[k] = ch_cnt_q[k];
      if (!en[k]) begin
        ch_cnt_d[k] = DIV_ZERO;
      end else if (evt_s[k]) begin
        ch_cnt_d[k] = DIV_ZERO;
      end else if (tick_s) begin
        ch_cnt_d[k] = ch_cnt_q[k] + DIV_ONE;
      end else begin
        ch_cnt_d[k] = ch_cnt_q[k];
      end
      // A disabled channel drops its ready flag; a set beats a coincident ack.
      if (!en[k]) begin
        tx_rdy_d[k] = 1'b0;
      end else if (evt_s[k] | repeat_req[k]) begin
        tx_rdy_d[k] = 1'b1;
      end else if (tx_ack[k]) begin
        tx_rdy_d[k] = 1'b0;
      end else begin
        tx_rdy_d[k] = tx_rdy_q[k];
      end
      // Overrun is sticky across channel disable; a new overrun beats a clear.
      if (evt_s[k] & tx_rdy_q[k] & ~tx_ack[k]) begin
        ovr_d[k] = 1'b1;
      end else if (ovr_clr[k]) begin
        ovr_d[k] = 1'b0;
      end else begin
        ovr_d[k] = ovr_q[k];
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_cnt_q <= BW'(0);
      tx_rdy_q   <= {NUM_CH{1'b0}};
      ovr_q      <= {NUM_CH{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
        ch_cnt_q[k] <= DIV_ZERO;
      end
    end else begin
      base_cnt_q <= base_cnt_d;
      tx_rdy_q   <= tx_rdy_d;
      ovr_q      <= ovr_d;
      for (int k = 0; k < NUM_CH; k++) begin
        ch_cnt_q[k] <= ch_cnt_d[k];
      end
    end
  end

  assign base_tick = tick_s;
  assign pre_alert = pa_s;
  assign tx_rdy    = tx_rdy_q;
  assign ovr       = ovr_q;

endmodule

// File: doc/tm_sr_sched.md
TM_SR_SCHED -- requirements
Module: tm_sr_sched

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, clock frequency in Hz (documentation and derivation of defaults only).
REQ-002 SHALL have parameter BASE_DIV, default CLK_FREQ/10, clock cycles per base period (100 ms at default); legal range >= 2.
REQ-003 SHALL have parameter NUM_CH, default 2, number of independent telemetry/service channels; legal range 1..8.
REQ-004 SHALL have parameter DIV_W, default 4, width of each per-channel period divider.
REQ-005 SHALL have parameter PRE_CYC, default 37400 (748 us frame time at 50 MHz), length in cycles of the pre-alert window; legal range 0..BASE_DIV-1.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port en  input  NUM_CH  per-channel enable.
REQ-009 SHALL have port div  input  NUM_CH*DIV_W  per-channel divider, channel k at bits [k*DIV_W +: DIV_W]; period = div base periods.
REQ-010 SHALL have port tx_ack  input  NUM_CH  per-channel transmit acknowledge pulse.
REQ-011 SHALL have port repeat_req  input  NUM_CH  per-channel repeat request pulse.
REQ-012 SHALL have port tx_rdy  output  NUM_CH  registered per-channel transmit-ready flag.
REQ-013 SHALL have port pre_alert  output  NUM_CH  per-channel warning ahead of the next channel event.
REQ-014 SHALL have port base_tick  output  1  one-cycle strobe at the end of every base period.
REQ-015 SHALL have port ovr  output  NUM_CH  registered sticky overrun flag.
REQ-016 SHALL have port ovr_clr  input  NUM_CH  per-channel overrun clear pulse.

Function
REQ-017 SHALL run a free-running base counter 0..BASE_DIV-1 with width clog2(BASE_DIV); base_tick = (base_cnt == BASE_DIV-1); counter wraps to 0 on the following edge.
REQ-018 SHALL treat div value 0 as 1 (effective divider d_eff >= 1).
REQ-019 SHALL keep per-channel counter ch_cnt[k], width DIV_W, incremented on base_tick while en[k]=1.
REQ-020 SHALL define event[k] = base_tick & en[k] & (ch_cnt[k] >= d_eff-1); on event ch_cnt[k] returns to 0.
REQ-021 SHALL, when div is reduced mid-run below the current count, fire event[k] on the next base_tick (the >= compare), never wrapping through 2^DIV_W.
REQ-022 SHALL hold ch_cnt[k] at 0, clear tx_rdy[k] and force pre_alert[k]=0 while en[k]=0; ovr[k] is retained.
REQ-023 SHALL set tx_rdy[k] on the edge after event[k] or repeat_req[k] (repeat only while en[k]=1); clear it on the edge after tx_ack[k]; set wins when set and ack coincide.
REQ-024 SHALL leave base and channel counters unaffected by repeat_req and tx_ack.
REQ-025 SHALL drive pre_alert[k] = en[k] & (ch_cnt[k] >= d_eff-1) & (base_cnt >= BASE_DIV-1-PRE_CYC) & ~base_tick, i.e. high exactly PRE_CYC cycles immediately before the event cycle, low on the event cycle; PRE_CYC=0 disables it.
REQ-026 SHALL set ovr[k] on the edge after event[k] when tx_rdy[k]=1 and tx_ack[k]=0 in that cycle; ovr_clr[k] clears it; set wins on coincidence.
REQ-027 SHALL treat all channels independently; simultaneous events on several channels are all registered in the same cycle.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force base_cnt, all ch_cnt, tx_rdy, ovr to 0; base_tick and pre_alert read 0 during reset.
REQ-029 SHALL, after rst deasserts, assert the first base_tick BASE_DIV-1 cycles later; rst mid-period discards any partial period and pending tx_rdy.

Verification (BASE_DIV=10, PRE_CYC=3, NUM_CH=2, DIV_W=4)
REQ-030 SHALL cover: en=01, div0=0 -> base_tick at cycles 9,19,29 after reset release; tx_rdy[0] rises cycle 10, no ovr while acked each period.
REQ-031 SHALL cover: en=10, div1=3 -> event[1] every 30 cycles (cycle 29,59); pre_alert[1] high at cycles 26,27,28 only, low at 29.
REQ-032 SHALL cover: tx_ack[0] coincident with event[0] -> tx_rdy[0] stays 1, ovr[0] stays 0; ack one cycle later -> tx_rdy[0]=0.
REQ-033 SHALL cover: no ack across two events on channel 0 -> ovr[0]=1 after second event; ovr_clr[0] pulse -> 0; ovr_clr coincident with new overrun -> stays 1.
REQ-034 SHALL cover: repeat_req[1] at cycle 5 -> tx_rdy[1]=1 at cycle 6, base/channel timing unchanged; div1 changed 5->2 with ch_cnt=3 -> event on next base_tick.
REQ-035 SHALL cover: rst pulse at cycle 15 and en[0] drop mid-period -> all outputs 0, next base_tick 9 cycles after reset release, ovr retained across en drop only.
